// File: rtl/uart_hamming_receiver_if.sv
// Receiver-side bus of the Hamming-protected UART link.
// rx         : serial line into the receiver (idle high)
// data_out   : decoded nibble
// data_valid : one-cycle strobe, data_out/corrected valid
// corrected  : single-bit error was fixed in this frame
// frame_err  : one-cycle strobe on a bad frame
// busy       : receiver FSM not idle
// master = the receiver, slave = whoever drives rx and consumes the results.
interface uart_hamming_receiver_if;
  logic       rx;
  logic [3:0] data_out;
  logic       data_valid;
  logic       corrected;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output data_out,
    output data_valid,
    output corrected,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  data_valid,
    input  corrected,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_hamming_receiver.sv
// Receive end of the Hamming-protected UART link. Deserialises 8N1 frames and decodes the
// Hamming(7,4) codeword in bits [6:0] of the byte (bit 7 is a pad that must be 0), correcting
// any single-bit error.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : uart_hamming_receiver_if.master (rx in; data_out, data_valid, corrected,
//         frame_err, busy out)
module uart_hamming_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16  // >= 4 and even
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_hamming_receiver_if.master       bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StDrain
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            corr_q, corr_d;
  logic            ferr_q, ferr_d;

  // Two-flop synchroniser; resets to the idle (high) line level.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Hamming(7,4) decode of the assembled byte; code[i] is position i+1.
  logic [6:0] code;
  logic [2:0] syn;
  logic [6:0] flip;
  logic [6:0] fixed;
  logic [3:0] nibble;

  always_comb begin
    code   = shift_q[6:0];
    syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
    syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
    syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
    flip   = '0;
    if (syn != 3'd0) begin
      flip = 7'b000_0001 << (syn - 3'd1);
    end
    fixed  = code ^ flip;
    nibble = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    corr_d    = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          // A line back high at mid-start was a glitch, not a frame.
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            ferr_d  = 1'b1;
            state_d = StDrain;
          end else if (shift_q[7]) begin
            ferr_d  = 1'b1;
            state_d = StIdle;
          end else begin
            valid_d = 1'b1;
            corr_d  = (syn != 3'd0);
            data_d  = nibble;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Wait out a break so a held-low line is not taken as a fresh start bit.
      StDrain: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      corr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      corr_q    <= corr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.corrected  = corr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_hamming_receiver.sv
// Directed bench for uart_hamming_receiver: clean, corrected, back-to-back, glitch, break,
// pad-error and mid-frame reset frames with hand-computed expected nibbles.
module tb_uart_hamming_receiver;

  localparam int unsigned Cpb = 16;

  logic clk;
  logic rst;

  uart_hamming_receiver_if bus ();

  uart_hamming_receiver #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Strobe monitor, sampled on the falling edge.
  int         cyc = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_overlap = 0;
  int         last_valid_cyc = 0;
  bit         busy_seen = 1'b0;
  logic [4:0] seen_q[$];  // {corrected, data_out} per data_valid

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
      seen_q.push_back({bus.corrected, bus.data_out});
    end
    if (bus.frame_err === 1'b1) n_ferr++;
    if (bus.data_valid === 1'b1 && bus.frame_err === 1'b1) n_overlap++;
    if (bus.busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(input logic [7:0] b, input int nbits);
    bus.rx = 1'b0;
    wait_cycles(Cpb);
    for (int i = 0; i < nbits; i++) begin
      bus.rx = b[i];
      wait_cycles(Cpb);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_bits);
    drive_bits(b, 8);
    bus.rx = 1'b1;
    wait_cycles(Cpb * stop_bits);
  endtask

  // One clean frame, then a check that exactly one strobe with the given result appeared.
  task automatic frame_expect(input string tag, input logic [7:0] b, input logic [3:0] nib,
                              input logic corr);
    int v0;
    int f0;
    logic [4:0] got;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(b, 2);
    check_eq({tag, "_nvalid"}, n_valid - v0, 1);
    check_eq({tag, "_nferr"}, n_ferr - f0, 0);
    got = (seen_q.size() > 0) ? seen_q[$] : 5'h1f;
    check_eq({tag, "_data"}, {28'd0, got[3:0]}, {28'd0, nib});
    check_eq({tag, "_corr"}, {31'd0, got[4]}, {31'd0, corr});
  endtask

  initial begin
    int v0;
    int f0;
    int t0;
    logic [7:0] flipped;

    bus.rx = 1'b1;
    rst    = 1'b1;
    wait_cycles(3);
    check_eq("rst_data_out", {28'd0, bus.data_out}, 0);
    check_eq("rst_valid", {31'd0, bus.data_valid}, 0);
    check_eq("rst_corr", {31'd0, bus.corrected}, 0);
    check_eq("rst_ferr", {31'd0, bus.frame_err}, 0);
    check_eq("rst_busy", {31'd0, bus.busy}, 0);
    rst = 1'b0;
    wait_cycles(4);

    // Clean 0x55 -> nibble B, plus strobe latency from the start edge (~9.5 bits + sync).
    t0 = cyc;
    frame_expect("clean55", 8'h55, 4'hB, 1'b0);
    check_eq("lat_min", (last_valid_cyc - t0 >= 153) ? 1 : 0, 1);
    check_eq("lat_max", (last_valid_cyc - t0 <= 157) ? 1 : 0, 1);

    // code[4] flipped -> syndrome 5, corrected back to B.
    frame_expect("syn5", 8'h45, 4'hB, 1'b1);

    // Every single-bit flip of 0x7F decodes to F with corrected set.
    for (int i = 0; i < 7; i++) begin
      flipped = 8'h7F ^ (8'h01 << i);
      frame_expect($sformatf("flip%0d", i), flipped, 4'hF, 1'b1);
    end

    // Back-to-back 0x00 then 0x7F with a single stop bit.
    v0 = n_valid;
    send_frame(8'h00, 1);
    send_frame(8'h7F, 1);
    wait_cycles(Cpb);
    check_eq("b2b_nvalid", n_valid - v0, 2);
    if (seen_q.size() >= 2) begin
      check_eq("b2b_first", {27'd0, seen_q[seen_q.size() - 2]}, {27'd0, 5'h00});
      check_eq("b2b_second", {27'd0, seen_q[seen_q.size() - 1]}, {27'd0, 5'h0F});
    end else begin
      check_eq("b2b_queue", seen_q.size(), 2);
    end

    // Glitch: short low pulse must be rejected and busy must drop by mid-start + 3.
    v0 = n_valid;
    f0 = n_ferr;
    busy_seen = 1'b0;
    bus.rx = 1'b0;
    wait_cycles(Cpb / 4);
    bus.rx = 1'b1;
    wait_cycles(Cpb / 2 + 3 - Cpb / 4);
    check_eq("glitch_busy_low", {31'd0, bus.busy}, 0);
    check_eq("glitch_busy_seen", {31'd0, busy_seen}, 1);
    wait_cycles(2 * Cpb);
    check_eq("glitch_strobes", (n_valid - v0) + (n_ferr - f0), 0);

    // Break: stop bit low and line held low for 3 more bits.
    v0 = n_valid;
    f0 = n_ferr;
    drive_bits(8'h55, 8);
    bus.rx = 1'b0;
    wait_cycles(4 * Cpb);
    check_eq("break_ferr", n_ferr - f0, 1);
    check_eq("break_nvalid", n_valid - v0, 0);
    check_eq("break_busy_held", {31'd0, bus.busy}, 1);
    bus.rx = 1'b1;
    wait_cycles(4);
    check_eq("break_busy_rel", {31'd0, bus.busy}, 0);
    wait_cycles(Cpb);
    frame_expect("after_break", 8'h55, 4'hB, 1'b0);

    // Pad error: load F first so a wrongly updated data_out would show.
    frame_expect("pre_pad", 8'h7F, 4'hF, 1'b0);
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'hD5, 2);
    check_eq("pad_ferr", n_ferr - f0, 1);
    check_eq("pad_nvalid", n_valid - v0, 0);
    check_eq("pad_hold", {28'd0, bus.data_out}, 32'hF);
    check_eq("pad_busy", {31'd0, bus.busy}, 0);

    // Reset in the middle of the data bits.
    v0 = n_valid;
    f0 = n_ferr;
    drive_bits(8'h55, 3);
    check_eq("mid_busy", {31'd0, bus.busy}, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_data", {28'd0, bus.data_out}, 0);
    check_eq("mid_rst_busy", {31'd0, bus.busy}, 0);
    bus.rx = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2 * Cpb);
    check_eq("mid_rst_strobes", (n_valid - v0) + (n_ferr - f0), 0);
    frame_expect("post_rst", 8'h55, 4'hB, 1'b0);

    check_eq("valid_ferr_overlap", n_overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so a stuck bench still ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_hamming_receiver.md
Name: uart_hamming_receiver

Overview:
- Receive end of the Hamming-protected UART link: deserialises 8N1 frames from the rx line and decodes the Hamming(7,4) codeword carried in bits [6:0].
- Corrects any single-bit error and presents the 4-bit nibble with a one-cycle valid strobe.
- Sits opposite the encoder plus UART transmitter path. Its frame format and bit mapping are fixed to match that path.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit. Legal values are ≥4 and even.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- data_out  output  4  decoded (corrected) nibble
- data_valid  output  1  one-cycle strobe; data_out/corrected valid this cycle
- corrected  output  1  high with data_valid when a single-bit error was fixed
- frame_err  output  1  one-cycle strobe on a bad frame
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst high, asynchronous) puts every output at 0, FSM in IDLE, synchroniser flops at 1, counters at 0. Reset mid-frame aborts the frame with no strobe.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
- Frame format: start bit (0), 8 data bits LSB first, 1 stop bit (1). Data byte = {pad, code[6:0]}, pad required to be 0.
- Codeword mapping: code[i] is Hamming position i+1.
  - pos1 = p1, pos2 = p2, pos3 = d0, pos4 = p4, pos5 = d1, pos6 = d2, pos7 = d3.
  - data_out = {d3, d2, d1, d0}.
- FSM states: IDLE, START, DATA, STOP, DRAIN.
  - IDLE -> START when rx_s == 0. The baud counter is cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then sample rx_s. If 1, it is a false start: go to IDLE with no strobe. If 0, go to DATA.
  - DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit) into a shift register, LSB first. A 3-bit bit index wraps 7 -> 0. After the 8th sample go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If the stop bit is 1 and pad is 0: decode, then return to IDLE.
    - If the stop bit is 0: pulse frame_err and go to DRAIN.
    - If pad is 1: pulse frame_err and go to IDLE.
  - DRAIN: stay until rx_s == 1, then go to IDLE. This prevents a break condition from being read as a new start.
- Decode:
  - Syndrome s = {s4, s2, s1}.
    - s1 = XOR of positions 1, 3, 5, 7.
    - s2 = XOR of positions 2, 3, 6, 7.
    - s4 = XOR of positions 4, 5, 6, 7.
  - If s ≠ 0, invert position s before extracting the data bits and set corrected = 1.
  - A parity-bit error (s = 1, 2 or 4) still sets corrected; data_out is unchanged.
  - A double error is miscorrected silently. This is the accepted SEC-only limitation.
- Latency: data_out, data_valid, corrected and frame_err are registered. They update on the clock edge after the stop-bit sample cycle.
  - data_valid, corrected and frame_err are single-cycle pulses.
  - data_out holds its value until the next valid frame.
- data_valid and frame_err are never high in the same cycle.
- busy is 0 in IDLE and 1 in all other states. It goes low in the same cycle data_valid or frame_err is asserted, except when the FSM enters DRAIN.
- Back-to-back frames: a start bit is accepted from IDLE on the cycle after the strobe. The minimum stop-bit dwell is therefore half a bit.

Test Plan:
- Nibble 4'b1011, byte 0x55, clean frame -> data_valid pulse, data_out = 4'hB, corrected = 0, frame_err = 0. Strobe arrives 1 cycle after the stop sample, ≈9.5 bit times + sync latency after the start edge.
- Byte 0x45 (0x55 with code[4] flipped, syndrome 5) -> data_out = 4'hB, corrected = 1. Repeat for each of the 7 single-bit flips of 0x7F (nibble F) -> data_out = 4'hF, corrected = 1 every time.
- Bytes 0x00 then 0x7F back-to-back with a 1-bit stop -> two data_valid pulses, data_out 4'h0 then 4'hF.
- Glitch: rx low for CLKS_PER_BIT/4 cycles, then high -> no strobe, busy returns low within CLKS_PER_BIT/2 + 3 cycles.
- Stop bit driven 0 and rx held low for 3 more bit times -> a single frame_err pulse, no data_valid, busy stays high until rx returns high. A following 0x55 frame decodes to 4'hB.
- Byte 0xD5 (pad = 1) -> frame_err = 1, no data_valid, data_out keeps its previous value.
- Assert rst during DATA -> all outputs 0 immediately. After release, a 0x55 frame -> data_out = 4'hB.
